ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_pkg.sv | 26 ++
 rtl/ccff_crc16.sv | 25 ++
 rtl/ccff_loader.sv | 173 +++++++++++++++++
 tb/tb_ccff_loader.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// ccff_pkg: shared state encoding, CRC constants and parameter defaults
// for the configuration-chain loader and its CRC helper.
package ccff_pkg;

    localparam int CHAIN_LEN_DEFAULT = 1024;
    localparam int PCLK_HALF_DEFAULT = 2;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        CLOCK,
        FINISH
    } state_t;

    // One MSB-first CRC-16-CCITT step for a single serial bit.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
        logic [15:0] shifted;
        shifted = {crc[14:0], 1'b0};
        return (crc[15] ^ din) ? (shifted ^ CRC_POLY) : shifted;
    endfunction

endpackage

// File: rtl/ccff_crc16.sv
// ccff_crc16: serial CRC-16-CCITT accumulator over the bits returned
// from the configuration-chain tail.
import ccff_pkg::*;

module ccff_crc16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    // Restart on init, otherwise fold in one bit per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_next(crc, din);
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: streams a byte-wide bitstream MSB-first into a configuration
// flip-flop chain, generating prog_clk with PCLK_HALF-cycle low/high phases.
// Optional feature macro: CCFF_LOADER_CRC_EN adds crc_out, a CRC-16-CCITT
// of the bits seen on ccff_tail at each prog_clk rising edge.
import ccff_pkg::*;

module ccff_loader #(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT,
    parameter int PCLK_HALF = PCLK_HALF_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       prog_clk,
    output logic       ccff_head,
    input  logic       ccff_tail,
    output logic       busy,
    output logic       done
`ifdef CCFF_LOADER_CRC_EN
    ,
    output logic [15:0] crc_out
`endif
);

    localparam logic [15:0] LAST_BIT   = 16'(CHAIN_LEN - 1);
    localparam logic [7:0]  PHASE_LAST = 8'(PCLK_HALF - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  buf_data;
    logic        buf_full;
    logic [7:0]  shreg;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  phase;
    logic        phase_end;
    logic        last_bit;
    logic        transfer;
    logic        load_shreg;
    logic        shift_shreg;

    assign phase_end = (phase == PHASE_LAST);
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign transfer  = byte_valid && byte_ready && !abort;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides every other transition out of a busy state.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   if (buf_full) next_state = SETUP;
            SETUP:   if (phase_end) next_state = CLOCK;
            CLOCK: begin
                if (phase_end) begin
                    if (last_bit) begin
                        next_state = FINISH;
                    end else if (bit_idx == 3'd7) begin
                        next_state = FETCH;
                    end else begin
                        next_state = SETUP;
                    end
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            next_state = IDLE;
        end
    end

    // Status outputs and datapath strobes decoded from the current state.
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == FINISH);
        byte_ready  = busy && !buf_full;
        load_shreg  = (state == FETCH) && (next_state == SETUP);
        shift_shreg = (state == CLOCK) && phase_end && (next_state != IDLE);
    end

    // One-byte input buffer: filled by a handshake, drained by FETCH, flushed on leaving a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data <= 8'h00;
            buf_full <= 1'b0;
        end else if ((state == IDLE) || (next_state == IDLE)) begin
            buf_full <= 1'b0;
        end else if (transfer) begin
            buf_data <= byte_in;
            buf_full <= 1'b1;
        end else if (load_shreg) begin
            buf_full <= 1'b0;
        end
    end

    // Shift register, chain bit counter, per-byte bit index and phase timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= 8'h00;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            phase   <= 8'd0;
        end else begin
            if ((state == IDLE) && start) begin
                bit_cnt <= 16'd0;
                bit_idx <= 3'd0;
            end
            if (load_shreg) begin
                shreg   <= buf_data;
                bit_idx <= 3'd0;
            end else if (shift_shreg) begin
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 16'd1;
                bit_idx <= bit_idx + 3'd1;
            end
            phase <= (next_state != state) ? 8'd0 : phase + 8'd1;
        end
    end

    // Registered chain pins: head carries the next MSB through SETUP and CLOCK, prog_clk is high in CLOCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_clk  <= 1'b0;
            ccff_head <= 1'b0;
        end else begin
            prog_clk <= (next_state == CLOCK);
            if ((next_state == SETUP) || (next_state == CLOCK)) begin
                if (load_shreg) begin
                    ccff_head <= buf_data[7];
                end else if (shift_shreg) begin
                    ccff_head <= shreg[6];
                end else begin
                    ccff_head <= shreg[7];
                end
            end else begin
                ccff_head <= 1'b0;
            end
        end
    end

`ifdef CCFF_LOADER_CRC_EN
    logic crc_sample;
    logic crc_init;
    assign crc_sample = (state == SETUP) && (next_state == CLOCK);
    assign crc_init   = (state == IDLE) && start;

    ccff_crc16 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (crc_init),
        .en    (crc_sample),
        .din   (ccff_tail),
        .crc   (crc_out)
    );
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: two loader instances (16-bit chain / half-period 1 and
// 12-bit chain / half-period 2) driven by load tasks; accepted bytes push
// their expected chain bits into per-instance queues which a negedge
// monitor pops on every prog_clk rising edge.
// Build with CCFF_LOADER_CRC_EN defined to include the crc_out checks.
module tb_ccff_loader;

    localparam int CL0 = 16;
    localparam int PH0 = 1;
    localparam int CL1 = 12;
    localparam int PH1 = 2;
    localparam int QD  = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start [2];
    logic abort [2];
    logic [7:0] byte_in [2];
    logic byte_valid [2];
    logic byte_ready [2];
    logic prog_clk [2];
    logic ccff_head [2];
    logic ccff_tail [2];
    logic busy [2];
    logic done [2];
`ifdef CCFF_LOADER_CRC_EN
    logic [15:0] crc_out [2];
`endif

    int total = 0;
    int bad = 0;
    bit q [2][QD];
    int wr [2];
    int rd [2];
    int loaded [2];
    int pulses [2];
    int done_cnt [2];
    int start_pulses [2];
    int start_done [2];
    logic [15:0] chain;

    always #5 clk = ~clk;

    ccff_loader #(.CHAIN_LEN(CL0), .PCLK_HALF(PH0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .byte_in(byte_in[0]), .byte_valid(byte_valid[0]), .byte_ready(byte_ready[0]),
        .prog_clk(prog_clk[0]), .ccff_head(ccff_head[0]), .ccff_tail(ccff_tail[0]),
        .busy(busy[0]), .done(done[0])
`ifdef CCFF_LOADER_CRC_EN
        , .crc_out(crc_out[0])
`endif
    );

    ccff_loader #(.CHAIN_LEN(CL1), .PCLK_HALF(PH1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .byte_in(byte_in[1]), .byte_valid(byte_valid[1]), .byte_ready(byte_ready[1]),
        .prog_clk(prog_clk[1]), .ccff_head(ccff_head[1]), .ccff_tail(ccff_tail[1]),
        .busy(busy[1]), .done(done[1])
`ifdef CCFF_LOADER_CRC_EN
        , .crc_out(crc_out[1])
`endif
    );

    // Fabric model for instance 0: a 16-stage chain clocked by prog_clk.
    wire pc0 = prog_clk[0];
    always @(posedge pc0 or negedge rst_n) begin
        if (!rst_n) chain <= 16'h0000;
        else        chain <= {chain[14:0], ccff_head[0]};
    end
    assign ccff_tail[0] = chain[15];
    assign ccff_tail[1] = 1'b0;

    function automatic int cl(input int d);
        return (d == 0) ? CL0 : CL1;
    endfunction

    function automatic int ph(input int d);
        return (d == 0) ? PH0 : PH1;
    endfunction

    // Reference CRC-16-CCITT over a 16-bit stream, MSB first.
    function automatic logic [15:0] crc_ref(input logic [15:0] bits);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ bits[i]) c = (c << 1) ^ 16'h1021;
            else                 c = c << 1;
        end
        return c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected bit per prog_clk rise, checks phase widths and done timing.
    initial begin
        bit prev_pc [2];
        bit prev_head [2];
        int hi_cnt [2];
        int lo_cnt [2];
        int idx;
        for (int d = 0; d < 2; d++) begin
            prev_pc[d] = 0; prev_head[d] = 0; hi_cnt[d] = 0; lo_cnt[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    prev_pc[d] = 0; prev_head[d] = 0; hi_cnt[d] = 0; lo_cnt[d] = 0;
                end else begin
                    if (prog_clk[d] && !prev_pc[d]) begin
                        idx = pulses[d] - start_pulses[d];
                        chk($sformatf("pulse_expected d%0d", d), (wr[d] > rd[d]) ? 1 : 0, 1);
                        if (wr[d] > rd[d]) begin
                            chk($sformatf("head_bit d%0d bit%0d", d, idx), int'(ccff_head[d]), int'(q[d][rd[d] % QD]));
                            chk($sformatf("head_setup d%0d bit%0d", d, idx), int'(prev_head[d]), int'(q[d][rd[d] % QD]));
                            rd[d]++;
                        end
                        if (idx % 8 != 0) chk($sformatf("pclk_low_width d%0d", d), lo_cnt[d], ph(d));
                        pulses[d]++;
                        hi_cnt[d] = 1;
                        lo_cnt[d] = 0;
                    end else if (prog_clk[d]) begin
                        hi_cnt[d]++;
                    end else begin
                        if (prev_pc[d]) chk($sformatf("pclk_high_width d%0d", d), hi_cnt[d], ph(d));
                        lo_cnt[d]++;
                    end
                    if (done[d]) begin
                        done_cnt[d]++;
                        chk($sformatf("done_after_all_bits d%0d", d), pulses[d] - start_pulses[d], cl(d));
                    end
                    prev_pc[d] = prog_clk[d];
                    prev_head[d] = ccff_head[d];
                end
            end
        end
    end

    // Pulse start for one cycle and open a fresh expected stream; called at posedge+1.
    task automatic begin_load(input int d);
        start_pulses[d] = pulses[d];
        start_done[d] = done_cnt[d];
        loaded[d] = 0;
        wr[d] = rd[d];
        start[d] = 1'b1;
        @(posedge clk);
        #1 start[d] = 1'b0;
    endtask

    // Offer one byte until accepted; accepted bits up to the chain length become expected output.
    task automatic send_byte(input int d, input logic [7:0] b);
        int budget;
        budget = 300;
        byte_in[d] = b;
        byte_valid[d] = 1'b1;
        @(negedge clk);
        while (!byte_ready[d] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!byte_ready[d]) begin
            chk($sformatf("byte_accept_timeout d%0d", d), 0, 1);
            @(posedge clk);
        end else begin
            @(posedge clk);
            for (int i = 7; i >= 0; i--) begin
                if (loaded[d] < cl(d)) begin
                    q[d][wr[d] % QD] = b[i];
                    wr[d]++;
                    loaded[d]++;
                end
            end
        end
        #1 byte_valid[d] = 1'b0;
    endtask

    // Wait (bounded) for done, then check the completed load's totals.
    task automatic wait_done(input int d);
        int budget;
        budget = 800;
        while (done_cnt[d] == start_done[d] && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("done_count d%0d", d), done_cnt[d] - start_done[d], 1);
        chk($sformatf("pulse_count d%0d", d), pulses[d] - start_pulses[d], cl(d));
        chk($sformatf("bits_left d%0d", d), wr[d] - rd[d], 0);
        chk($sformatf("busy_after_done d%0d", d), int'(busy[d]), 0);
        chk($sformatf("ready_after_done d%0d", d), int'(byte_ready[d]), 0);
    endtask

    task automatic run_load(input int d, input logic [7:0] b0, input logic [7:0] b1, input int stall);
        begin_load(d);
        send_byte(d, b0);
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
        end
        send_byte(d, b1);
        wait_done(d);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int budget;
        logic [7:0] r0;
        logic [7:0] r1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 0; abort[d] = 0; byte_in[d] = 0; byte_valid[d] = 0;
            wr[d] = 0; rd[d] = 0; loaded[d] = 0; pulses[d] = 0; done_cnt[d] = 0;
            start_pulses[d] = 0; start_done[d] = 0;
        end
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_prog_clk d%0d", d), int'(prog_clk[d]), 0);
            chk($sformatf("reset_head d%0d", d), int'(ccff_head[d]), 0);
            chk($sformatf("reset_busy d%0d", d), int'(busy[d]), 0);
            chk($sformatf("reset_ready d%0d", d), int'(byte_ready[d]), 0);
            chk($sformatf("reset_done d%0d", d), int'(done[d]), 0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] 16-bit load of A5 3C");
        run_load(0, 8'hA5, 8'h3C, 0);

        $display("[TB] second load, tail returns first-load bits");
        run_load(0, 8'hA5, 8'h3C, 0);
`ifdef CCFF_LOADER_CRC_EN
        chk("crc_golden", int'(crc_out[0]), int'(crc_ref(16'hA53C)));
        repeat (5) @(posedge clk);
        #1 chk("crc_held", int'(crc_out[0]), int'(crc_ref(16'hA53C)));
`endif

        $display("[TB] 12-bit load of FF 0F");
        run_load(1, 8'hFF, 8'h0F, 0);

        $display("[TB] stalled second byte");
        begin_load(0);
        send_byte(0, 8'hA5);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_prog_clk_low", int'(prog_clk[0]), 0);
        chk("stall_no_done", done_cnt[0] - start_done[0], 0);
        chk("stall_pulses", pulses[0] - start_pulses[0], 8);
        send_byte(0, 8'h3C);
        wait_done(0);

        $display("[TB] abort after five pulses");
        begin_load(0);
        send_byte(0, 8'hA5);
        send_byte(0, 8'h3C);
        budget = 200;
        while (pulses[0] - start_pulses[0] < 5 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        chk("abort_reach_5", pulses[0] - start_pulses[0], 5);
        wr[0] = rd[0];
        abort[0] = 1'b1;
        @(posedge clk);
        #1 abort[0] = 1'b0;
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_prog_clk", int'(prog_clk[0]), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt[0] - start_done[0], 0);
        chk("abort_no_more_pulses", pulses[0] - start_pulses[0], 5);
        run_load(0, 8'hA5, 8'h3C, 0);

        $display("[TB] reset during CLOCK");
        begin_load(0);
        send_byte(0, 8'h5A);
        send_byte(0, 8'hC3);
        budget = 200;
        @(negedge clk);
        while (!prog_clk[0] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("reset_reach_clock", int'(prog_clk[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_prog_clk", int'(prog_clk[0]), 0);
        chk("midrst_head", int'(ccff_head[0]), 0);
        chk("midrst_busy", int'(busy[0]), 0);
        chk("midrst_ready", int'(byte_ready[0]), 0);
        chk("midrst_done", int'(done[0]), 0);
        chk("midrst_no_done", done_cnt[0] - start_done[0], 0);
        wr[0] = rd[0];
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_load(0, 8'h96, 8'h1E, 0);

        $display("[TB] randomized loads");
        for (int i = 0; i < 8; i++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            run_load(i % 2, r0, r1, int'($urandom_range(0, 12)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
